// File: rtl/of_hazard_controller_if.sv
// Operand-fetch issue interface: decoded instruction fields in, pipeline enables out.
interface of_hazard_controller_if;
  logic        instr_valid;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic        uses_rs2;
  logic [3:0]  rd_addr;
  logic        rd_we;
  logic [1:0]  stall_class;
  logic        branch_resolved;
  logic        branch_taken;
  logic        pc_en;
  logic        ifof_en;
  logic        bubble;
  logic        flush;
  logic        halted;
  logic [15:0] busy_mask;

  modport master (
    output instr_valid, rs1_addr, rs2_addr, uses_rs2, rd_addr, rd_we,
           stall_class, branch_resolved, branch_taken,
    input  pc_en, ifof_en, bubble, flush, halted, busy_mask
  );

  modport slave (
    input  instr_valid, rs1_addr, rs2_addr, uses_rs2, rd_addr, rd_we,
           stall_class, branch_resolved, branch_taken,
    output pc_en, ifof_en, bubble, flush, halted, busy_mask
  );
endinterface

// File: rtl/of_hazard_controller.sv
// Operand-fetch issue controller: RAW scoreboard, branch freeze and halt latch.
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module of_hazard_controller #(
  parameter int unsigned WB_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  of_hazard_controller_if.slave  bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q [16];
  logic [2:0]  cnt_d [16];
  logic [15:0] busy;
  logic        hazard;
  logic        issue;
  logic        sb_load;

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign hazard  = bus.instr_valid &
                   (busy[bus.rs1_addr] | (bus.uses_rs2 & busy[bus.rs2_addr]));
  assign issue   = bus.instr_valid & (state_q == RUN) & ~hazard;
  assign sb_load = issue & bus.rd_we & (bus.stall_class != 2'b11);

  assign bus.pc_en     = (state_q == RUN) & ~hazard;
  assign bus.ifof_en   = (state_q == RUN) & ~hazard;
  assign bus.bubble    = ~issue;
  assign bus.flush     = (state_q == BR_WAIT) & bus.branch_resolved & bus.branch_taken;
  assign bus.halted    = (state_q == HALT);
  assign bus.busy_mask = busy;

  // A load on the destination counter takes priority over its decrement.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_d[i] = busy[i] ? cnt_q[i] - 3'd1 : '0;
      if (sb_load && (bus.rd_addr == 4'(i))) begin
        cnt_d[i] = 3'(WB_LAT);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (issue && bus.stall_class == 2'b10) state_d = BR_WAIT;
        else if (issue && bus.stall_class == 2'b11) state_d = HALT;
      end
      BR_WAIT: if (bus.branch_resolved) state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_cnt_q;
  logic        stall_ev;

  assign stall_ev = bus.instr_valid & (state_q == RUN) & hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && stall_q != '1) stall_q <= stall_q + 16'd1;
      if (bus.flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_of_hazard_controller.sv
// Bench for of_hazard_controller: ready-time scoreboard model checked every cycle plus directed literals.
module tb_of_hazard_controller;
  localparam int unsigned WB = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  of_hazard_controller_if bus_if ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  of_hazard_controller #(.WB_LAT(WB)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
`else
  of_hazard_controller #(.WB_LAT(WB)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each register records the cycle at which its value becomes readable.
  int cyc;
  int ready_at [16];
  int mode;            // 0 running, 1 waiting on branch, 2 halted
  int m_stalls;
  int m_flushes;
  bit mon_en;

  function automatic bit m_busy(input logic [3:0] r);
    return ready_at[r] > cyc;
  endfunction

  function automatic bit m_hazard();
    return bus_if.instr_valid &&
           (m_busy(bus_if.rs1_addr) || (bus_if.uses_rs2 && m_busy(bus_if.rs2_addr)));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ready_at[i] = 0;
      mode = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      bit haz, iss;
      haz = m_hazard();
      iss = bus_if.instr_valid && mode == 0 && !haz;
      if (bus_if.instr_valid && mode == 0 && haz && m_stalls < 65535) m_stalls++;
      if (mode == 1 && bus_if.branch_resolved && bus_if.branch_taken && m_flushes < 65535) m_flushes++;
      if (iss && bus_if.rd_we && bus_if.stall_class != 2'b11)
        ready_at[bus_if.rd_addr] = cyc + 1 + int'(WB);
      if (mode == 0 && iss && bus_if.stall_class == 2'b10) mode = 1;
      else if (mode == 0 && iss && bus_if.stall_class == 2'b11) mode = 2;
      else if (mode == 1 && bus_if.branch_resolved) mode = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] exp_mask;
      bit haz, iss;
      for (int i = 0; i < 16; i++) exp_mask[i] = m_busy(4'(i));
      haz = m_hazard();
      iss = bus_if.instr_valid && mode == 0 && !haz;
      chk("m_busy_mask", 32'(bus_if.busy_mask), 32'(exp_mask));
      chk("m_pc_en",     32'(bus_if.pc_en),   32'(mode == 0 && !haz));
      chk("m_ifof_en",   32'(bus_if.ifof_en), 32'(mode == 0 && !haz));
      chk("m_bubble",    32'(bus_if.bubble),  32'(!iss));
      chk("m_flush",     32'(bus_if.flush),
          32'(mode == 1 && bus_if.branch_resolved && bus_if.branch_taken));
      chk("m_halted",    32'(bus_if.halted),  32'(mode == 2));
`ifdef HAZARD_PERF_EN
      chk("m_stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      chk("m_flush_count",  32'(flush_count),  32'(m_flushes));
`endif
    end
  end

  task automatic drive(input bit v, input logic [3:0] rs1, input logic [3:0] rs2, input bit u2,
                       input logic [3:0] rd, input bit we, input logic [1:0] cls,
                       input bit br, input bit bt);
    bus_if.instr_valid     = v;
    bus_if.rs1_addr        = rs1;
    bus_if.rs2_addr        = rs2;
    bus_if.uses_rs2        = u2;
    bus_if.rd_addr         = rd;
    bus_if.rd_we           = we;
    bus_if.stall_class     = cls;
    bus_if.branch_resolved = br;
    bus_if.branch_taken    = bt;
  endtask

  task automatic idle(input bit br, input bit bt);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 2'b00, br, bt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; mon_en = 0; mode = 0;
    m_stalls = 0; m_flushes = 0;
    for (int i = 0; i < 16; i++) ready_at[i] = 0;

    // Reset with arbitrary, active-looking inputs
    reset = 1'b1;
    drive(1'b1, 4'd5, 4'd6, 1'b1, 4'd7, 1'b1, 2'b11, 1'b1, 1'b1);
    tick(); tick();
    reset = 1'b0;
    idle(1'b0, 1'b0);
    mon_en = 1;
    #1;
    chk("rst_busy_mask", 32'(bus_if.busy_mask), 32'h0);
    chk("rst_halted",    32'(bus_if.halted),    32'h0);
    chk("rst_pc_en",     32'(bus_if.pc_en),     32'h1);
    chk("rst_flush",     32'(bus_if.flush),     32'h0);
    chk("rst_bubble",    32'(bus_if.bubble),    32'h1);

    // RAW hazard on r5: exactly WB stall cycles
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 2'b00, 1'b0, 1'b0);
    #1 chk("raw_prod_bubble", 32'(bus_if.bubble), 32'h0);
    tick();
    drive(1'b1, 4'd5, 4'd0, 1'b0, 4'd6, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < int'(WB); k++) begin
      #1;
      chk("raw_stall_pc_en",  32'(bus_if.pc_en),     32'h0);
      chk("raw_stall_bubble", 32'(bus_if.bubble),    32'h1);
      chk("raw_stall_mask",   32'(bus_if.busy_mask), 32'h0020);
      tick();
    end
    #1;
    chk("raw_issue_pc_en",  32'(bus_if.pc_en),     32'h1);
    chk("raw_issue_bubble", 32'(bus_if.bubble),    32'h0);
    chk("raw_issue_mask",   32'(bus_if.busy_mask), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("raw_stall_cycles", 32'(stall_cycles), 32'd3);
`endif
    tick();

    // Independent back-to-back, then a reload of r3
    drive(1'b1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 2'b01, 1'b0, 1'b0);
    #1 chk("ind_bubble0", 32'(bus_if.bubble), 32'h0);
    tick();
    drive(1'b1, 4'd4, 4'd0, 1'b1, 4'd3, 1'b1, 2'b00, 1'b0, 1'b0);
    #1 chk("ind_bubble1", 32'(bus_if.bubble), 32'h0);
    chk("ind_mask1", 32'(bus_if.busy_mask), 32'h0008);
    tick();
    drive(1'b1, 4'd0, 4'd1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); tick();
    #1 chk("reload_still_busy", 32'(bus_if.busy_mask), 32'h0008);
    tick();
    #1 chk("reload_cleared", 32'(bus_if.busy_mask), 32'h0);

    // Taken branch resolved two cycles after issue
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 2'b10, 1'b0, 1'b0);
    #1 chk("br_issue_pc_en", 32'(bus_if.pc_en), 32'h1);
    tick();
    idle(1'b0, 1'b0);
    #1 chk("br_wait_pc_en", 32'(bus_if.pc_en), 32'h0);
    tick();
    idle(1'b1, 1'b1);
    #1 chk("br_taken_flush", 32'(bus_if.flush), 32'h1);
    chk("br_taken_pc_en", 32'(bus_if.pc_en), 32'h0);
    tick();
    idle(1'b0, 1'b0);
    #1 chk("br_taken_run", 32'(bus_if.pc_en), 32'h1);

    // Not-taken branch
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    idle(1'b0, 1'b0);
    tick();
    idle(1'b1, 1'b0);
    #1 chk("br_nt_flush", 32'(bus_if.flush), 32'h0);
    tick();
    idle(1'b1, 1'b1);
    #1 chk("br_run_ignores", 32'(bus_if.flush), 32'h0);
    chk("br_nt_run", 32'(bus_if.pc_en), 32'h1);
    tick();

    // Halt behind a busy source; halt's own rd must not mark the scoreboard
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd9, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd9, 4'd0, 1'b0, 4'd4, 1'b1, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < int'(WB); k++) begin
      #1;
      chk("halt_stall_pc_en", 32'(bus_if.pc_en),  32'h0);
      chk("halt_stall_halted", 32'(bus_if.halted), 32'h0);
      tick();
    end
    #1 chk("halt_issue_bubble", 32'(bus_if.bubble), 32'h0);
    tick();
    idle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("halt_halted", 32'(bus_if.halted),    32'h1);
      chk("halt_pc_en",  32'(bus_if.pc_en),     32'h0);
      chk("halt_flush",  32'(bus_if.flush),     32'h0);
      chk("halt_mask",   32'(bus_if.busy_mask), 32'h0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(1'b0, 1'b0);
    #1 chk("halt_reset_halted", 32'(bus_if.halted), 32'h0);
    chk("halt_reset_pc_en", 32'(bus_if.pc_en), 32'h1);
    tick();

    // Reset while waiting on a branch with r7 busy
    drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    idle(1'b0, 1'b0);
    #1 chk("bw_pc_en", 32'(bus_if.pc_en), 32'h0);
    chk("bw_mask", 32'(bus_if.busy_mask), 32'h0080);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("bw_reset_pc_en", 32'(bus_if.pc_en), 32'h1);
    chk("bw_reset_mask", 32'(bus_if.busy_mask), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("bw_reset_stalls",  32'(stall_cycles), 32'h0);
    chk("bw_reset_flushes", 32'(flush_count),  32'h0);
`endif
    tick(); tick();

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/of_hazard_controller.md
# of_hazard_controller

Issue controller for the operand-fetch stage of the 4-stage pipeline. It keeps a per-register scoreboard of in-flight writes for the 16-entry register file and stalls the PC and the IF/OF register on read-after-write hazards. It freezes fetch after a control-transfer instruction until the branch resolves, and latches the machine into a halted state on a halt instruction. It consumes the fields decoded in operand fetch (source/destination addresses, write-enable, and the 2-bit stall class from control-rod bits [9:8]) and drives the pipeline-register enables.

## Interface
- WB_LAT, 3: cycles from issue until the destination value is readable by operand fetch (1..7)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  IF/OF register holds a real instruction
- rs1_addr  input  4  first source register (instruction bits [15:12])
- rs2_addr  input  4  second source register (instruction bits [19:16])
- uses_rs2  input  1  instruction reads rs2
- rd_addr  input  4  destination register
- rd_we  input  1  instruction writes rd
- stall_class  input  2  00 normal, 01 normal, 10 control transfer, 11 halt
- branch_resolved  input  1  EX reports branch outcome this cycle
- branch_taken  input  1  outcome, qualified by branch_resolved
- pc_en  output  1  PC may advance
- ifof_en  output  1  IF/OF register may load
- bubble  output  1  OF/EX register loads a NOP this cycle
- flush  output  1  invalidate IF/OF register (wrong-path fetch)
- halted  output  1  halt state reached
- busy_mask  output  16  bit i set when register i has a pending write

## Operation
- Scoreboard: one 3-bit down-counter per register. Register i is busy when counter[i] != 0. busy_mask is combinational from the counters.
- hazard = instr_valid & ((busy[rs1_addr]) | (uses_rs2 & busy[rs2_addr])).
- issue = instr_valid & state==RUN & !hazard.
- Each cycle, every nonzero counter decrements by 1. On issue with rd_we set and stall_class != 11, counter[rd_addr] loads WB_LAT. The load overrides that counter's decrement. A load to an already-busy register simply reloads it.
- States:
  - RUN: normal issue.
  - BR_WAIT: fetch frozen.
  - HALT: terminal.
- Transitions:
  - RUN -> BR_WAIT on issue with stall_class==10.
  - RUN -> HALT on issue with stall_class==11.
  - BR_WAIT -> RUN on branch_resolved.
  - HALT is left only by reset.
- Outputs:
  - pc_en = ifof_en = (state==RUN) & !hazard.
  - bubble = !issue.
  - flush = (state==BR_WAIT) & branch_resolved & branch_taken.
  - halted = (state==HALT).
- instr_valid low in RUN: pc_en=1, bubble=1, and no scoreboard load.
- Hazard check applies to control-transfer and halt instructions too. They stay in RUN, stalled, until their sources are clear.
- branch_resolved while in RUN or HALT is ignored.

## Timing
- Reset values: all counters 0, state RUN, pc_en=1, ifof_en=1, bubble=1 (instr_valid is low after reset), flush=0, halted=0, busy_mask=0.
- Reset asserted mid-operation clears everything on the next edge, regardless of state.
- All enables and flush are combinational from registered state plus current inputs. They are used on the same edge.
- Producer issued at cycle t with WB_LAT=3: counter = 3, 2, 1 at t+1..t+3 and 0 at t+4. A back-to-back dependent instruction stalls at t+1..t+3 and issues at t+4, giving exactly WB_LAT stall cycles.
- Branch issued at t: BR_WAIT from t+1. branch_resolved at cycle r gives flush at r (if taken) and RUN at r+1. Resolution at t+1 costs one frozen cycle.
- The scoreboard keeps decrementing during BR_WAIT and HALT.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cycles [15:0] and flush_count [15:0].
  - stall_cycles increments on each cycle with instr_valid & state==RUN & hazard.
  - flush_count increments on each flush.
  - Both saturate at 16'hFFFF and reset to 0.
- HAZARD_PERF_EN not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset pulse with arbitrary inputs -> next cycle busy_mask=0, halted=0, pc_en=1, flush=0.
- Issue rd=5, rd_we=1; next instruction rs1=5 (WB_LAT=3) -> pc_en=0 and bubble=1 for 3 cycles, issue on cycle 4, busy_mask bit 5 clear on that cycle. With HAZARD_PERF_EN, stall_cycles=3.
- Independent instructions back-to-back (rs ≠ any pending rd) -> pc_en=1 every cycle, zero bubbles. A write to r3 then to r3 again -> counter reloads to 3.
- Branch (class 10) issues; branch_resolved=1, branch_taken=1 two cycles later -> pc_en=0 for 2 cycles, flush=1 in the resolve cycle, RUN next cycle. Repeating with taken=0 -> flush stays 0.
- Halt (class 11) with rs1 busy -> stalls until clear, then halted=1 and pc_en=0 permanently. branch_resolved is ignored. Reset returns to RUN.
- Reset asserted while in BR_WAIT with r7 busy -> next cycle state RUN, busy_mask=0. With HAZARD_PERF_EN, counters are 0.
